// File: rtl/screen_pkg.sv
// Screen/app state codes and menu indices shared by the
// state controller and the downstream output mux.
package screen_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_MENU        = 4'b0000;
  localparam state_t S_VOLUME      = 4'b0001;
  localparam state_t S_POKEMON     = 4'b0010;
  localparam state_t S_POKE_OVER   = 4'b0011;
  localparam state_t S_FRUIT       = 4'b0100;
  localparam state_t S_POTION      = 4'b0101;
  localparam state_t S_LOADING     = 4'b0110;
  localparam state_t S_POTION_LOSE = 4'b0111;
  localparam state_t S_POTION_WIN  = 4'b1000;
  localparam state_t S_FRUIT_OVER  = 4'b1001;
  localparam state_t S_LOCKED      = 4'b1111;

  localparam logic [1:0] SEL_VOLUME  = 2'd0;
  localparam logic [1:0] SEL_POKEMON = 2'd1;
  localparam logic [1:0] SEL_FRUIT   = 2'd2;
  localparam logic [1:0] SEL_POTION  = 2'd3;

  function automatic state_t sel_to_app(
    input logic [1:0] sel
  );
    state_t s;
    unique case (sel)
      SEL_VOLUME:  s = S_VOLUME;
      SEL_POKEMON: s = S_POKEMON;
      SEL_FRUIT:   s = S_FRUIT;
      default:     s = S_POTION;
    endcase
    return s;
  endfunction

  function automatic logic is_result(
    input state_t s
  );
    return (s == S_POKE_OVER) ||
           (s == S_POTION_LOSE) ||
           (s == S_POTION_WIN) ||
           (s == S_FRUIT_OVER);
  endfunction

endpackage

// File: rtl/screen_state_ctrl_hold_timer.sv
// Saturating tick counter with clear, enable and an
// expire flag raised on the tick that reaches the last count.
module hold_timer #(
  parameter int TW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] last,
  output logic          expire
);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != '1))
      cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/screen_state_ctrl.sv
// Board screen sequencer: locked, menu, loading, app and
// result screens, driven by button and game-event pulses.
module screen_state_ctrl
  import screen_pkg::*;
#(
  parameter int LOAD_TICKS   = 2000,
  parameter int RESULT_TICKS = 3000,
  parameter int TW           = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       unlock,
  input  logic       lock_req,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       btn_back,
  input  logic       pokemon_over,
  input  logic       fruit_over,
  input  logic       potion_win,
  input  logic       potion_lose,
  output logic [3:0] state,
  output logic [1:0] menu_sel,
  output logic       state_changed,
  output logic       load_busy
);

  localparam logic [TW-1:0] LOAD_LAST = TW'(LOAD_TICKS - 1);
  localparam logic [TW-1:0] RES_LAST  = TW'(RESULT_TICKS - 1);

  state_t     state_q, state_d;
  state_t     target_q, target_d;
  logic [1:0] sel_q, sel_d;
  logic       changed_q, busy_q;

  logic          in_load, in_res;
  logic          tmr_en, tmr_clr, tmr_exp;
  logic [TW-1:0] tmr_last;

  assign in_load  = (state_q == S_LOADING);
  assign in_res   = is_result(state_q);
  assign tmr_en   = tick_en && (in_load || in_res);
  assign tmr_last = in_load ? LOAD_LAST : RES_LAST;
  // Any transition restarts the hold count for the next screen.
  assign tmr_clr  = (state_d != state_q);

  hold_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .last   (tmr_last),
    .expire (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    target_d = target_q;
    if (lock_req) begin
      state_d = S_LOCKED;
    end else begin
      case (state_q)
        S_LOCKED: begin
          if (unlock) state_d = S_MENU;
        end
        S_MENU: begin
          if (btn_ok) begin
            target_d = sel_to_app(sel_q);
            state_d  = S_LOADING;
          end else if (btn_up && !btn_down) begin
            sel_d = sel_q - 2'd1;
          end else if (btn_down && !btn_up) begin
            sel_d = sel_q + 2'd1;
          end
        end
        S_LOADING: begin
          if (tmr_exp)       state_d = target_q;
          else if (btn_back) state_d = S_MENU;
        end
        S_VOLUME: begin
          if (btn_back) state_d = S_MENU;
        end
        S_POKEMON: begin
          if (pokemon_over)  state_d = S_POKE_OVER;
          else if (btn_back) state_d = S_MENU;
        end
        S_FRUIT: begin
          if (fruit_over)    state_d = S_FRUIT_OVER;
          else if (btn_back) state_d = S_MENU;
        end
        S_POTION: begin
          if (potion_lose)     state_d = S_POTION_LOSE;
          else if (potion_win) state_d = S_POTION_WIN;
          else if (btn_back)   state_d = S_MENU;
        end
        S_POKE_OVER, S_POTION_LOSE,
        S_POTION_WIN, S_FRUIT_OVER: begin
          if (tmr_exp || btn_ok) state_d = S_MENU;
        end
        default: state_d = S_LOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOCKED;
      sel_q     <= SEL_VOLUME;
      target_q  <= S_VOLUME;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      target_q  <= target_d;
      changed_q <= (state_d != state_q);
      busy_q    <= (state_d == S_LOADING);
    end
  end

  assign state         = state_q;
  assign menu_sel      = sel_q;
  assign state_changed = changed_q;
  assign load_busy     = busy_q;

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Scoreboard bench for screen_state_ctrl: directed sequences
// plus a random pulse soak against a behavioural model.
module tb_screen_state_ctrl;

  localparam int LT = 4;
  localparam int RT = 5;

  localparam logic [10:0] TICK = 11'h001;
  localparam logic [10:0] UNL  = 11'h002;
  localparam logic [10:0] LCK  = 11'h004;
  localparam logic [10:0] UP   = 11'h008;
  localparam logic [10:0] DN   = 11'h010;
  localparam logic [10:0] OK   = 11'h020;
  localparam logic [10:0] BK   = 11'h040;
  localparam logic [10:0] PKO  = 11'h080;
  localparam logic [10:0] FRO  = 11'h100;
  localparam logic [10:0] PW   = 11'h200;
  localparam logic [10:0] PL   = 11'h400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_en = 0, unlock = 0, lock_req = 0;
  logic btn_up = 0, btn_down = 0, btn_ok = 0, btn_back = 0;
  logic pokemon_over = 0, fruit_over = 0;
  logic potion_win = 0, potion_lose = 0;
  logic [3:0] state;
  logic [1:0] menu_sel;
  logic state_changed, load_busy;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] sel;
    logic       ch;
    logic       busy;
  } exp_t;
  exp_t sb[$];

  // behavioural model
  int m_state, m_sel, m_target, m_ticks;
  int app_code[4] = '{1, 2, 4, 5};

  always #5 clk = ~clk;

  screen_state_ctrl #(
    .LOAD_TICKS(LT), .RESULT_TICKS(RT), .TW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
    .unlock(unlock), .lock_req(lock_req),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_ok(btn_ok), .btn_back(btn_back),
    .pokemon_over(pokemon_over), .fruit_over(fruit_over),
    .potion_win(potion_win), .potion_lose(potion_lose),
    .state(state), .menu_sel(menu_sel),
    .state_changed(state_changed), .load_busy(load_busy)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 15; m_sel = 0; m_target = 1; m_ticks = 0;
  endtask

  task automatic model(input logic [10:0] p);
    int nxt;
    bit tick, ok, bk, up, dn;
    exp_t e;
    tick = |(p & TICK); ok = |(p & OK); bk = |(p & BK);
    up = |(p & UP); dn = |(p & DN);
    nxt = m_state;
    if (|(p & LCK)) nxt = 15;
    else if (m_state == 15) begin
      if (|(p & UNL)) nxt = 0;
    end else if (m_state == 0) begin
      if (ok) begin
        m_target = app_code[m_sel];
        nxt = 6;
      end else if (up != dn) begin
        m_sel = up ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
      end
    end else if (m_state == 6) begin
      if (tick && m_ticks + 1 == LT) nxt = m_target;
      else if (bk) nxt = 0;
      else if (tick) m_ticks++;
    end else if (m_state inside {3, 7, 8, 9}) begin
      if (tick && m_ticks + 1 == RT) nxt = 0;
      else if (ok) nxt = 0;
      else if (tick) m_ticks++;
    end else begin
      if (m_state == 2 && |(p & PKO)) nxt = 3;
      else if (m_state == 4 && |(p & FRO)) nxt = 9;
      else if (m_state == 5 && |(p & PL)) nxt = 7;
      else if (m_state == 5 && |(p & PW)) nxt = 8;
      else if (bk) nxt = 0;
    end
    e.ch = (nxt != m_state);
    if (nxt != m_state) m_ticks = 0;
    m_state = nxt;
    e.st = 4'(m_state);
    e.sel = 2'(m_sel);
    e.busy = (m_state == 6);
    sb.push_back(e);
  endtask

  task automatic step(input logic [10:0] p);
    @(negedge clk);
    tick_en = p[0]; unlock = p[1]; lock_req = p[2];
    btn_up = p[3]; btn_down = p[4]; btn_ok = p[5];
    btn_back = p[6]; pokemon_over = p[7]; fruit_over = p[8];
    potion_win = p[9]; potion_lose = p[10];
    model(p);
    @(posedge clk); #1;
    {tick_en, unlock, lock_req, btn_up, btn_down, btn_ok,
     btn_back, pokemon_over, fruit_over, potion_win,
     potion_lose} = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(TICK);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_state", state, e.st);
        chk("sb_sel", menu_sel, e.sel);
        chk("sb_changed", state_changed, e.ch);
        chk("sb_busy", load_busy, e.busy);
        chk("sb_legal", (state inside {[10:14]}) ? 1 : 0, 0);
      end
    end
  end

  initial begin
    logic [10:0] p;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 15);
    chk("rst_sel", menu_sel, 0);
    chk("rst_changed", state_changed, 0);
    chk("rst_busy", load_busy, 0);
    @(negedge clk); rst_n = 1'b1;

    step(UNL);
    chk("unlock_state", state, 0);
    chk("unlock_pulse", state_changed, 1);
    step(0);
    chk("unlock_pulse_once", state_changed, 0);
    step(UP);
    chk("up_wrap", menu_sel, 3);
    step(UP | DN);
    chk("updn_hold", menu_sel, 3);
    step(DN); step(DN);
    chk("down_x2", menu_sel, 1);
    step(OK);
    chk("ok_loading", state, 6);
    chk("busy_hi", load_busy, 1);
    ticks(LT - 1);
    chk("load_hold", state, 6);
    ticks(1);
    chk("load_done", state, 2);
    chk("busy_lo", load_busy, 0);

    step(BK);
    chk("back_menu", state, 0);
    step(DN); step(DN);
    step(OK); ticks(LT);
    chk("potion", state, 5);
    step(PW | PL);
    chk("potion_both", state, 7);
    ticks(RT - 1);
    chk("res_hold", state, 7);
    ticks(1);
    chk("res_expire", state, 0);
    step(OK); ticks(LT);
    step(PW);
    chk("potion_win", state, 8);
    ticks(2);
    step(OK);
    chk("res_ok_early", state, 0);

    step(UP);
    step(OK); ticks(LT);
    chk("fruit", state, 4);
    step(PKO);
    chk("drop_evt", state, 4);
    chk("drop_no_pulse", state_changed, 0);
    step(FRO);
    chk("fruit_over", state, 9);
    ticks(RT);
    chk("fruit_ret", state, 0);
    step(OK);
    step(LCK | BK);
    chk("lock_wins", state, 15);
    step(UNL);
    chk("relock_menu", state, 0);
    chk("sel_kept", menu_sel, 2);

    step(UP);
    step(OK); ticks(LT);
    step(PKO);
    chk("poke_over", state, 3);
    ticks(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 15);
    chk("arst_sel", menu_sel, 0);
    chk("arst_changed", state_changed, 0);
    chk("arst_timer", int'(dut.u_timer.cnt_q), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      p = '0;
      p[0] = 1'($urandom_range(0, 1));
      p[1] = ($urandom_range(0, 5) == 0);
      p[2] = ($urandom_range(0, 49) == 0);
      for (int b = 3; b < 11; b++)
        p[b] = ($urandom_range(0, 7) == 0);
      step(p);
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
